adc_spi_responder: RTL and testbench
====================================

# adc_spi_responder

Synthesizable SPI responder that emulates the on-board 8-channel 12-bit serial ADC (16-clock frame, 3-bit channel address on DIN, 4 leading zeros plus 12 data bits MSB-first on DOUT). It sits between a test or loopback pin group and an internal sample source, so the existing ADC master can be exercised in hardware-in-the-loop setups and by a second FPGA. It oversamples the SPI pins on the system clock and serves a per-frame snapshot of the selected channel.

## Interface
- `DATA_W`, 12: sample width.
- `NUM_CH`, 8: number of channels; address width is clog2(NUM_CH) = 3.
- `SYNC_STAGES`, 2: synchronizer depth on every SPI input.
- `clk`  in  1  system clock; must be at least 8× the SCLK frequency.
- `reset_n`  in  1  asynchronous, active-low reset.
- `spi_sclk`  in  1  SPI clock from the master; idles high or low.
- `spi_cs_n`  in  1  chip select, active-low.
- `spi_din`  in  1  address bits from the master.
- `spi_dout`  out  1  serial data to the master.
- `spi_dout_oe`  out  1  output enable for the DOUT pad; 1 only while the frame is active.
- `ch_values`  in  NUM_CH*DATA_W  flat channel sample array; channel k is in bits [k*DATA_W +: DATA_W].
- `cur_ch`  out  3  channel being shifted out in the current frame.
- `next_addr`  out  3  address captured in the last completed frame.
- `frame_done`  out  1  one-cycle pulse when rising edge 16 is seen.
- `frame_err`  out  1  one-cycle pulse when CS deasserts mid-frame.

## Operation
- SCLK, CS_n and DIN pass through identical SYNC_STAGES synchronizers, so their relative alignment is preserved. Edges are detected on the synchronized SCLK and CS_n.
- States:
  - IDLE: CS high, oe=0.
  - ACTIVE: CS low, counting SCLK edges.
- `bit_cnt` runs 0..16 and counts rising SCLK edges in the current frame.
- On CS fall (IDLE→ACTIVE):
  - cur_ch=0.
  - Load the 16-bit shift register with {4'b0, ch_values[0]}.
  - Drive bit 15; oe=1; bit_cnt=0.
- On a rising edge:
  - bit_cnt++.
  - At bit_cnt values 3, 4, 5 after the increment, shift DIN into the addr register (ADD2 first).
  - At 16: frame_done=1, next_addr=addr, cur_ch=addr.
- On a falling edge:
  - bit_cnt=0: ignored. This covers the first falling edge when SCLK idles high.
  - 1..15: shift left and drive the next bit.
  - 16 (continuous CS low): load {4'b0, ch_values[cur_ch]}, drive bit 15, bit_cnt=0.
- On CS rise (ACTIVE→IDLE):
  - oe=0, dout=0, cur_ch=0.
  - If bit_cnt is not 0 and not 16, pulse frame_err.
- Sample data is snapshotted only at frame load. Changes to ch_values mid-frame do not affect the frame in flight.
- Simultaneous CS rise and an SCLK edge in the same clk cycle: the CS rise wins and the SCLK edge is discarded.
- Reset values: spi_dout=0, spi_dout_oe=0, cur_ch=0, next_addr=0, frame_done=0, frame_err=0, bit_cnt=0, state IDLE.
- Reset asserted mid-frame aborts the frame immediately and does not pulse frame_err.
- After reset release, a frame starts only on a fresh CS fall. If CS is already low at release, the block waits for CS high and then a new CS fall.

## Timing
- Pin-to-action latency is SYNC_STAGES+1 clk cycles (3 by default) for every edge: DOUT and oe update 3 clk after the SCLK fall or CS fall on the pin.
- SCLK high and low phases must each be at least 4 clk cycles. The master then samples stable data on the rising edge.
- frame_done rises 3 clk after rising edge 16 on the pin. next_addr and cur_ch are valid in the same cycle as frame_done.
- Frame period is 16 SCLK cycles. There is no dead time between frames while CS stays low.

## Structure
- Package `adc_spi_pkg`:
  - constants FRAME_BITS=16, LEAD_ZEROS=4, ADDR_FIRST_EDGE=3, ADDR_BITS=3;
  - state enum {IDLE, ACTIVE}.
- Sub-module `sync_edge_detect`: N-stage synchronizer plus registered rise/fall pulses.
  - Instantiated for SCLK and CS_n.
  - DIN uses the same synchronizer without the edge outputs.
- Top level holds the FSM, bit counter, address register and shift register.

## Test plan
- Reset: hold reset_n=0 with CS low and SCLK toggling → oe=0, dout=0, cur_ch=0, no pulses.
- Single frame, ch_values[0]=0xA5C, DIN address 3'b101 on rising edges 3–5 → master reads 0x0A5C, frame_done pulses once, next_addr=5.
- Two back-to-back frames with CS held low, ch_values[5]=0x123 → second frame reads 0x0123, cur_ch=5 during it.
- CS raised after 7 rising edges → frame_err pulses once, cur_ch=0, and the next frame returns the ch0 value.
- ch_values[0] changes from 0xFFF to 0x000 at rising edge 8 → the current frame still reads 0x0FFF and the next frame reads 0x0000.
- Both SCLK idle polarities, and SCLK fall coincident with CS rise → identical DOUT bit sequence, and no shift after CS rise.

Source files
------------

// File: rtl/adc_spi_pkg.sv
// Shared constants, state encoding and helpers for the serial ADC emulator.
package adc_spi_pkg;

    localparam int unsigned FRAME_BITS      = 16;
    localparam int unsigned LEAD_ZEROS      = 4;
    localparam int unsigned ADDR_FIRST_EDGE = 3;
    localparam int unsigned ADDR_BITS       = 3;
    localparam int unsigned CNT_W           = $clog2(FRAME_BITS + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    // True for the rising-edge counts that carry address bits (ADD2 first).
    function automatic logic is_addr_edge(input logic [CNT_W-1:0] cnt);
        return (cnt >= CNT_W'(ADDR_FIRST_EDGE)) &&
               (cnt <  CNT_W'(ADDR_FIRST_EDGE + ADDR_BITS));
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// N-stage synchronizer with registered rise/fall pulses aligned to the synced level.
module sync_edge_detect #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              rise_q;
    logic              fall_q;

    // Pulses compare the last two stages, so they appear together with the synced level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            rise_q <= sync_q[STAGES-2] & ~sync_q[STAGES-1];
            fall_q <= ~sync_q[STAGES-2] & sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/adc_spi_responder.sv
// SPI responder emulating an 8-channel 12-bit serial ADC, oversampled on clk.
module adc_spi_responder
    import adc_spi_pkg::*;
#(
    parameter int unsigned DATA_W      = 12,
    parameter int unsigned NUM_CH      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     spi_sclk,
    input  logic                     spi_cs_n,
    input  logic                     spi_din,
    output logic                     spi_dout,
    output logic                     spi_dout_oe,
    input  logic [NUM_CH*DATA_W-1:0] ch_values,
    output logic [ADDR_BITS-1:0]     cur_ch,
    output logic [ADDR_BITS-1:0]     next_addr,
    output logic                     frame_done,
    output logic                     frame_err
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic din_sync, din_rise, din_fall;
    logic unused_sync;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]      cnt_inc;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [ADDR_BITS-1:0]  cur_ch_q, cur_ch_d;
    logic [ADDR_BITS-1:0]  next_addr_q, next_addr_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic                  dout_q, dout_d;
    logic                  oe_q, oe_d;
    logic                  frame_done_q, frame_done_d;
    logic                  frame_err_q, frame_err_d;
    logic [FRAME_BITS-1:0] word_ch0, word_cur;

    sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (spi_sclk),
        .q_o     (sclk_lvl),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    // CS resets low so a CS held low across reset release is not seen as a fresh fall.
    sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_cs (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (spi_cs_n),
        .q_o     (cs_lvl),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_din (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (spi_din),
        .q_o     (din_sync),
        .rise_o  (din_rise),
        .fall_o  (din_fall)
    );

    assign unused_sync = ^{sclk_lvl, cs_lvl, din_rise, din_fall};

    // Frame words: leading zeros come from zero-extension of the sample.
    assign word_ch0 = FRAME_BITS'(ch_values[DATA_W-1:0]);
    assign word_cur = FRAME_BITS'(ch_values[32'(cur_ch_q) * DATA_W +: DATA_W]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            addr_q       <= '0;
            cur_ch_q     <= '0;
            next_addr_q  <= '0;
            shift_q      <= '0;
            dout_q       <= 1'b0;
            oe_q         <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            addr_q       <= addr_d;
            cur_ch_q     <= cur_ch_d;
            next_addr_q  <= next_addr_d;
            shift_q      <= shift_d;
            dout_q       <= dout_d;
            oe_q         <= oe_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        addr_d       = addr_q;
        cur_ch_d     = cur_ch_q;
        next_addr_d  = next_addr_q;
        shift_d      = shift_q;
        dout_d       = dout_q;
        oe_d         = oe_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        cnt_inc      = bit_cnt_q + CNT_W'(1);

        unique case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = ACTIVE;
                    cur_ch_d  = '0;
                    addr_d    = '0;
                    shift_d   = word_ch0;
                    dout_d    = word_ch0[FRAME_BITS-1];
                    oe_d      = 1'b1;
                    bit_cnt_d = '0;
                end
            end
            ACTIVE: begin
                // CS rise has priority; an SCLK edge in the same cycle is dropped.
                if (cs_rise) begin
                    state_d     = IDLE;
                    oe_d        = 1'b0;
                    dout_d      = 1'b0;
                    cur_ch_d    = '0;
                    bit_cnt_d   = '0;
                    frame_err_d = (bit_cnt_q != '0) && (bit_cnt_q != CNT_FULL);
                end else if (sclk_rise && (bit_cnt_q != CNT_FULL)) begin
                    bit_cnt_d = cnt_inc;
                    if (is_addr_edge(cnt_inc)) begin
                        addr_d = {addr_q[ADDR_BITS-2:0], din_sync};
                    end
                    if (cnt_inc == CNT_FULL) begin
                        frame_done_d = 1'b1;
                        next_addr_d  = addr_q;
                        cur_ch_d     = addr_q;
                    end
                end else if (sclk_fall) begin
                    if (bit_cnt_q == CNT_FULL) begin
                        shift_d   = word_cur;
                        dout_d    = word_cur[FRAME_BITS-1];
                        addr_d    = '0;
                        bit_cnt_d = '0;
                    end else if (bit_cnt_q != '0) begin
                        shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
                        dout_d  = shift_q[FRAME_BITS-2];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign spi_dout    = dout_q;
    assign spi_dout_oe = oe_q;
    assign cur_ch      = cur_ch_q;
    assign next_addr   = next_addr_q;
    assign frame_done  = frame_done_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Self-checking bench: acts as the ADC master and predicts each frame from the ADC protocol.
module tb_adc_spi_responder;

    localparam int unsigned DATA_W = 12;
    localparam int unsigned NUM_CH = 8;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic                     spi_sclk;
    logic                     spi_cs_n;
    logic                     spi_din;
    logic                     spi_dout;
    logic                     spi_dout_oe;
    logic [NUM_CH*DATA_W-1:0] ch_values;
    logic [2:0]               cur_ch;
    logic [2:0]               next_addr;
    logic                     frame_done;
    logic                     frame_err;

    int n_tests  = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    typedef struct {
        logic [11:0] ch0;
        logic [2:0]  addr;
        bit          idle_hi;
        logic [15:0] exp_word;
    } vec_t;

    always #5 clk = ~clk;

    adc_spi_responder #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .spi_sclk    (spi_sclk),
        .spi_cs_n    (spi_cs_n),
        .spi_din     (spi_din),
        .spi_dout    (spi_dout),
        .spi_dout_oe (spi_dout_oe),
        .ch_values   (ch_values),
        .cur_ch      (cur_ch),
        .next_addr   (next_addr),
        .frame_done  (frame_done),
        .frame_err   (frame_err)
    );

    // Pulse counters: a pulse stuck high for several cycles counts more than once.
    always @(negedge clk) begin
        if (frame_done) done_cnt++;
        if (frame_err)  err_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int k, input logic [11:0] v);
        ch_values[k*DATA_W +: DATA_W] = v;
    endtask

    function automatic logic [15:0] adc_word(input int k);
        logic [NUM_CH*DATA_W-1:0] v;
        v = ch_values;
        return {4'b0000, v[k*DATA_W +: DATA_W]};
    endfunction

    task automatic cs_start(input bit idle_hi);
        spi_sclk = idle_hi;
        tick(2);
        spi_cs_n = 1'b0;
        tick(6);
    endtask

    task automatic frame_end(input bit idle_hi, input bit coincide);
        if (!idle_hi && !coincide) begin
            spi_sclk = 1'b0;
            tick(5);
        end
        if (coincide) spi_sclk = 1'b0;
        spi_cs_n = 1'b1;
        tick(6);
    endtask

    // Master side: low phase then high phase per bit, sampling DOUT at each rising edge.
    task automatic spi_frame(input logic [2:0] addr, input int n_rise, input int chg_edge,
                             input int chg_k, input logic [11:0] chg_val,
                             output logic [15:0] rd, output logic [2:0] mid_ch);
        rd     = '0;
        mid_ch = '0;
        for (int e = 1; e <= n_rise; e++) begin
            spi_sclk = 1'b0;
            spi_din  = (e >= 3 && e <= 5) ? addr[5-e] : 1'b0;
            tick(5);
            rd = {rd[14:0], spi_dout};
            if (e == 8) mid_ch = cur_ch;
            spi_sclk = 1'b1;
            if (e == chg_edge) set_ch(chg_k, chg_val);
            tick(5);
        end
    endtask

    initial begin
        vec_t        tbl [4];
        logic [15:0] rd;
        logic [15:0] exp_w;
        logic [2:0]  mid;
        logic [2:0]  a;
        logic [2:0]  exp_ch;
        logic [2:0]  last_addr;
        bit          ih;
        bit          co;
        int          burst;

        tbl[0] = '{12'hA5C, 3'd5, 1'b0, 16'h0A5C};
        tbl[1] = '{12'hFFF, 3'd7, 1'b1, 16'h0FFF};
        tbl[2] = '{12'h000, 3'd0, 1'b0, 16'h0000};
        tbl[3] = '{12'h801, 3'd2, 1'b1, 16'h0801};

        ch_values = '0;
        spi_din   = 1'b0;
        spi_cs_n  = 1'b0;
        spi_sclk  = 1'b0;
        reset_n   = 1'b0;

        // Reset held with CS low and SCLK toggling.
        for (int i = 0; i < 8; i++) begin
            spi_sclk = ~spi_sclk;
            tick(5);
        end
        check("rst_oe", 32'(spi_dout_oe), 32'd0);
        check("rst_dout", 32'(spi_dout), 32'd0);
        check("rst_cur_ch", 32'(cur_ch), 32'd0);
        check("rst_next_addr", 32'(next_addr), 32'd0);
        check("rst_pulses", 32'(done_cnt + err_cnt), 32'd0);

        // Release with CS still low: no frame until a fresh CS fall.
        reset_n = 1'b1;
        spi_frame(3'd1, 16, 0, 0, 12'h0, rd, mid);
        check("rel_cs_low_oe", 32'(spi_dout_oe), 32'd0);
        check("rel_cs_low_done", 32'(done_cnt), 32'd0);
        spi_cs_n = 1'b1;
        tick(6);

        // Table-driven single frames.
        for (int i = 0; i < 4; i++) begin
            set_ch(0, tbl[i].ch0);
            done_cnt = 0;
            err_cnt  = 0;
            cs_start(tbl[i].idle_hi);
            check($sformatf("tbl%0d_oe_on", i), 32'(spi_dout_oe), 32'd1);
            spi_frame(tbl[i].addr, 16, 0, 0, 12'h0, rd, mid);
            check($sformatf("tbl%0d_word", i), 32'(rd), 32'(tbl[i].exp_word));
            check($sformatf("tbl%0d_mid_ch", i), 32'(mid), 32'd0);
            check($sformatf("tbl%0d_done", i), 32'(done_cnt), 32'd1);
            check($sformatf("tbl%0d_next_addr", i), 32'(next_addr), 32'(tbl[i].addr));
            check($sformatf("tbl%0d_cur_ch", i), 32'(cur_ch), 32'(tbl[i].addr));
            frame_end(tbl[i].idle_hi, 1'b0);
            check($sformatf("tbl%0d_err", i), 32'(err_cnt), 32'd0);
            check($sformatf("tbl%0d_oe_off", i), 32'(spi_dout_oe), 32'd0);
            check($sformatf("tbl%0d_cur_ch_off", i), 32'(cur_ch), 32'd0);
        end

        // Back-to-back frames with CS held low.
        set_ch(0, 12'h456);
        set_ch(5, 12'h123);
        done_cnt = 0;
        err_cnt  = 0;
        cs_start(1'b0);
        spi_frame(3'd5, 16, 0, 0, 12'h0, rd, mid);
        check("b2b_first", 32'(rd), 32'h0456);
        spi_frame(3'd3, 16, 0, 0, 12'h0, rd, mid);
        check("b2b_second", 32'(rd), 32'h0123);
        check("b2b_cur_ch_mid", 32'(mid), 32'd5);
        check("b2b_done", 32'(done_cnt), 32'd2);
        check("b2b_next_addr", 32'(next_addr), 32'd3);
        frame_end(1'b0, 1'b0);
        check("b2b_err", 32'(err_cnt), 32'd0);

        // CS raised after 7 rising edges.
        done_cnt = 0;
        err_cnt  = 0;
        cs_start(1'b1);
        spi_frame(3'd6, 7, 0, 0, 12'h0, rd, mid);
        spi_cs_n = 1'b1;
        tick(6);
        check("abort_err", 32'(err_cnt), 32'd1);
        check("abort_done", 32'(done_cnt), 32'd0);
        check("abort_cur_ch", 32'(cur_ch), 32'd0);
        check("abort_next_addr", 32'(next_addr), 32'd3);
        check("abort_dout", 32'(spi_dout), 32'd0);
        cs_start(1'b1);
        spi_frame(3'd0, 16, 0, 0, 12'h0, rd, mid);
        check("after_abort_word", 32'(rd), 32'h0456);
        frame_end(1'b1, 1'b0);

        // Sample change mid-frame only affects the following frame.
        set_ch(0, 12'hFFF);
        cs_start(1'b0);
        spi_frame(3'd0, 16, 8, 0, 12'h000, rd, mid);
        check("snap_cur", 32'(rd), 32'h0FFF);
        spi_frame(3'd0, 16, 0, 0, 12'h0, rd, mid);
        check("snap_next", 32'(rd), 32'h0000);
        frame_end(1'b0, 1'b0);

        // SCLK fall coincident with CS rise mid-frame: no shift, error pulse.
        set_ch(0, 12'h3C5);
        err_cnt = 0;
        cs_start(1'b1);
        spi_frame(3'd2, 8, 0, 0, 12'h0, rd, mid);
        frame_end(1'b1, 1'b1);
        check("coin_mid_err", 32'(err_cnt), 32'd1);
        check("coin_mid_dout", 32'(spi_dout), 32'd0);
        check("coin_mid_oe", 32'(spi_dout_oe), 32'd0);
        // Coincident at end of an idle-low frame: no reload, no error.
        cs_start(1'b0);
        spi_frame(3'd2, 16, 0, 0, 12'h0, rd, mid);
        check("coin_end_word", 32'(rd), 32'h03C5);
        frame_end(1'b0, 1'b1);
        check("coin_end_err", 32'(err_cnt), 32'd1);
        check("coin_end_oe", 32'(spi_dout_oe), 32'd0);

        // Reset mid-frame: abort without error, then wait for a fresh CS fall.
        done_cnt = 0;
        err_cnt  = 0;
        cs_start(1'b0);
        spi_frame(3'd4, 5, 0, 0, 12'h0, rd, mid);
        reset_n = 1'b0;
        tick(3);
        check("rstmid_oe", 32'(spi_dout_oe), 32'd0);
        check("rstmid_next_addr", 32'(next_addr), 32'd0);
        reset_n = 1'b1;
        spi_frame(3'd4, 16, 0, 0, 12'h0, rd, mid);
        check("rstmid_err", 32'(err_cnt), 32'd0);
        check("rstmid_idle", 32'(spi_dout_oe + 32'(done_cnt)), 32'd0);
        spi_cs_n = 1'b1;
        tick(6);

        // Randomized bursts checked against the protocol model.
        for (int it = 0; it < 24; it++) begin
            for (int k = 0; k < NUM_CH; k++) set_ch(k, 12'($urandom));
            ih       = 1'($urandom_range(0, 1));
            co       = 1'($urandom_range(0, 1));
            burst    = int'($urandom_range(1, 3));
            done_cnt = 0;
            err_cnt  = 0;
            exp_ch   = '0;
            last_addr = '0;
            cs_start(ih);
            for (int f = 0; f < burst; f++) begin
                a     = 3'($urandom);
                exp_w = adc_word(int'(exp_ch));
                spi_frame(a, 16, int'($urandom_range(1, 16)), int'($urandom_range(0, NUM_CH - 1)),
                          12'($urandom), rd, mid);
                check($sformatf("rnd%0d_f%0d_word", it, f), 32'(rd), 32'(exp_w));
                check($sformatf("rnd%0d_f%0d_mid_ch", it, f), 32'(mid), 32'(exp_ch));
                exp_ch    = a;
                last_addr = a;
            end
            frame_end(ih, co);
            check($sformatf("rnd%0d_done", it), 32'(done_cnt), 32'(burst));
            check($sformatf("rnd%0d_err", it), 32'(err_cnt), 32'd0);
            check($sformatf("rnd%0d_next_addr", it), 32'(next_addr), 32'(last_addr));
            check($sformatf("rnd%0d_oe_off", it), 32'(spi_dout_oe), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
